// File: rtl/mul_pkg.sv
// Shared constants for the accumulator datapath: operand width and controller state encoding.
package mul_pkg;

  localparam int unsigned OP_W = 128;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/tree_accum_ctrl_if.sv
// Operand-in / result-out handshake bundle for tree_accum_ctrl.
interface tree_accum_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import mul_pkg::*;

  logic             in_valid;
  logic [OP_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [OP_W-1:0]  out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/adder_tree.sv
// Combinational balanced adder tree: sum of N OP_W-bit lanes, mod 2^OP_W.
module adder_tree
  import mul_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0][OP_W-1:0] in,
  output logic [OP_W-1:0]        sum
);

  localparam int unsigned LV = $clog2(N);

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [(N>>l)-1:0][OP_W-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = in;
    end else begin : g_node
      for (genvar k = 0; k < (N >> l); k++) begin : g_add
        assign v[k] = g_lvl[l-1].v[2*k] + g_lvl[l-1].v[2*k+1];
      end
    end
  end

  assign sum = g_lvl[LV].v[0];

endmodule

// File: rtl/tree_accum_ctrl.sv
// Collects operand beats into N lanes, folds each full or final group into an
// accumulator through one adder tree, and presents the message sum and count.
module tree_accum_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  tree_accum_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N-1:0][OP_W-1:0] lanes_q, lanes_d;
  logic [OP_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [OP_W-1:0]        tree_sum;
  logic                   accept;

  adder_tree #(.N(N)) u_tree (
    .in  (lanes_q),
    .sum (tree_sum)
  );

  assign accept = (state_q == FILL) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (accept && (bus.in_last || idx_q == IDX_W'(N-1))) state_d = REDUCE;
      REDUCE:  state_d = last_q ? DONE : FILL;
      DONE:    if (bus.out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == DONE);
    bus.out_sum   = (state_q == DONE) ? acc_q : '0;
    bus.out_count = (state_q == DONE) ? cnt_q : '0;
  end

  // last_q remembers whether the group now being reduced closes the message.
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: if (accept) begin
        lanes_d[idx_q] = bus.in_data;
        idx_d          = idx_q + IDX_W'(1);
        cnt_d          = cnt_q + CNT_W'(1);
        last_d         = bus.in_last;
      end
      REDUCE: begin
        acc_d   = acc_q + tree_sum;
        lanes_d = '0;
        idx_d   = '0;
      end
      DONE: if (bus.out_ready) begin
        acc_d  = '0;
        cnt_d  = '0;
        last_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_tree_accum_ctrl.sv
// Directed bench for tree_accum_ctrl (N=8): table of messages plus hand-written
// backpressure and reset sequences.
module tb_tree_accum_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  tree_accum_ctrl_if #(.CNT_W(32)) bus ();

  tree_accum_ctrl #(.N(8), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  n;
    logic [127:0] base;
    logic [127:0] step;
    logic [127:0] exp_sum;
    logic [31:0]  exp_cnt;
    int unsigned  exp_stalls;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers n beats base, base+step, ...; returns the cycles spent waiting on in_ready.
  task automatic send_beats(input int unsigned n, input logic [127:0] base,
                            input logic [127:0] step, output int unsigned stalls);
    int unsigned w;
    stalls = 0;
    for (int unsigned i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 128'(i) * step;
      bus.in_last  = (i == n - 1);
      w = 0;
      while (!bus.in_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) chk("in_ready_timeout", 128'(bus.in_ready), 128'd1);
      stalls += w;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Called #1 after the edge accepting the last beat.
  task automatic finish_msg(input string tag, input logic [127:0] exp_sum,
                            input logic [31:0] exp_cnt);
    chk({tag, "_ov_reduce"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_ir_reduce"}, 128'(bus.in_ready), 128'd0);
    tick();
    chk({tag, "_ov_done"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_sum"}, bus.out_sum, exp_sum);
    chk({tag, "_cnt"}, 128'(bus.out_count), 128'(exp_cnt));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ov_after"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_ir_after"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_sum_after"}, bus.out_sum, 128'd0);
  endtask

  initial begin
    int unsigned stalls;
    logic [127:0] all_ones;
    all_ones = '1;

    vecs[0] = '{3,  128'd1,   128'd1, 128'd6,   32'd3,  0};
    vecs[1] = '{9,  128'd1,   128'd0, 128'd9,   32'd9,  1};
    vecs[2] = '{2,  all_ones, 128'd3, 128'd1,   32'd2,  0};
    vecs[3] = '{8,  128'd3,   128'd0, 128'd24,  32'd8,  0};
    vecs[4] = '{1,  128'd42,  128'd0, 128'd42,  32'd1,  0};
    vecs[5] = '{16, 128'd1,   128'd1, 128'd136, 32'd16, 1};
    vecs[6] = '{17, 128'd2,   128'd0, 128'd34,  32'd17, 2};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_sum", bus.out_sum, 128'd0);
    chk("rst_out_count", 128'(bus.out_count), 128'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int unsigned v = 0; v < 7; v++) begin
      send_beats(vecs[v].n, vecs[v].base, vecs[v].step, stalls);
      chk($sformatf("vec%0d_stalls", v), 128'(stalls), 128'(vecs[v].exp_stalls));
      finish_msg($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt);
    end

    // Result held under backpressure while garbage is offered on the input.
    send_beats(2, 128'd5, 128'd2, stalls);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 128'd99;
    bus.in_last  = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      chk("bp_ov", 128'(bus.out_valid), 128'd1);
      chk("bp_sum", bus.out_sum, 128'd12);
      chk("bp_ir", 128'(bus.in_ready), 128'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_ir_after", 128'(bus.in_ready), 128'd1);
    send_beats(1, 128'd4, 128'd0, stalls);
    finish_msg("bp_next", 128'd4, 32'd1);

    // Reset mid-message discards the partial group immediately.
    for (int unsigned i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 128'd10;
      tick();
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mrst_out_count", 128'(bus.out_count), 128'd0);
    tick();
    rst = 1'b0;
    tick();
    send_beats(1, 128'd5, 128'd0, stalls);
    finish_msg("mrst_next", 128'd5, 32'd1);

    // Reset while the result is presented drops it at once.
    send_beats(2, 128'd7, 128'd0, stalls);
    tick();
    chk("drst_ov_pre", 128'(bus.out_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("drst_ov", 128'(bus.out_valid), 128'd0);
    chk("drst_sum", bus.out_sum, 128'd0);
    chk("drst_ir", 128'(bus.in_ready), 128'd1);
    tick();
    rst = 1'b0;
    tick();
    send_beats(2, 128'd1, 128'd1, stalls);
    finish_msg("drst_next", 128'd3, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_accum_ctrl.md
TREE_ACCUM_CTRL -- requirements
Module: tree_accum_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning adder_tree lane count; legal values 2, 4, 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the per-message operand counter.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  an operand beat is offered.
REQ-006 in_data  input  128  operand value.
REQ-007 in_last  input  1  this beat is the final operand of the message.
REQ-008 in_ready  output  1  the block accepts the beat this cycle.
REQ-009 out_valid  output  1  the result is presented.
REQ-010 out_sum  output  128  sum of all operands in the message, mod 2^128.
REQ-011 out_count  output  CNT_W  number of operands in the message, mod 2^CNT_W.
REQ-012 out_ready  input  1  the consumer accepts the result.

Function
REQ-013 The block SHALL have three states: FILL, REDUCE and DONE.
REQ-014 A beat SHALL be accepted only on an edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in FILL.
REQ-015 In FILL, an accepted beat SHALL write in_data to lane[idx], increment idx and increment the operand counter.
REQ-016 FILL SHALL go to REDUCE on an accepted beat with in_last=1 or idx=N-1; both together SHALL cause one REDUCE only.
REQ-017 In REDUCE, the block SHALL apply acc <= acc + adder_tree sum of all N lanes (mod 2^128), zero all lanes, set idx to 0, and hold in_ready at 0 for exactly that one cycle.
REQ-018 REDUCE SHALL go to DONE if the group held the last beat, otherwise to FILL.
REQ-019 Lanes not written in a partial group SHALL contribute zero to the sum.
REQ-020 In DONE, out_valid SHALL be 1 and out_sum and out_count SHALL equal acc and the counter, held stable until handshake.
REQ-021 A DONE handshake (out_valid and out_ready) SHALL clear acc and the counter and go to FILL; in_ready SHALL first return to 1 on the following cycle.
REQ-022 out_valid SHALL rise in the second cycle after the edge that accepts the last beat.
REQ-023 in_valid and in_data SHALL be ignored in REDUCE and DONE.
REQ-024 Every message SHALL contain at least one beat, because in_last is carried on a beat.
REQ-025 Outside DONE, out_valid SHALL be 0 and out_sum and out_count SHALL be 0.

Reset
REQ-026 Asserting rst at any time, including mid-message, SHALL asynchronously apply: state FILL, idx 0, all lanes 0, acc 0, counter 0, in_ready 1, out_valid 0, out_sum 0, out_count 0.
REQ-027 A partial message interrupted by reset SHALL be discarded; the first beat accepted after rst is released SHALL start a new message.

Structure
REQ-028 The state encoding constants and the operand width constant OP_W=128 SHALL live in the shared mul_pkg package.
REQ-029 The block SHALL instantiate exactly one existing adder_tree with parameter N, with its in port driven from the lane registers; that adder_tree SHALL be the only sub-module.
REQ-030 The adder_tree output SHALL be consumed only in REDUCE.

Verification
REQ-031 N=8, beats 1, 2, 3 (in_last on 3) -> out_valid 2 cycles after the third accept, out_sum=6, out_count=3.
REQ-032 N=8, nine beats of 1 (in_last on the ninth) -> in_ready 0 for exactly 1 cycle after the 8th beat, then out_sum=9, out_count=9.
REQ-033 N=8, beats 2^128-1 then 2 (last) -> out_sum=1, out_count=2.
REQ-034 N=8, message 5, 7 (last) with out_ready held 0 for 5 cycles -> out_valid=1, out_sum=12 and in_ready=0 throughout; after the handshake, message 4 (last) -> out_sum=4, out_count=1.
REQ-035 N=8, rst pulsed after 4 beats of 10 -> all outputs 0 immediately; then message 5 (last) -> out_sum=5, out_count=1.
REQ-036 N=8, exactly 8 beats of 3 with in_last on the 8th -> a single REDUCE, out_sum=24, out_count=8.
